multicycle_controller: RTL and testbench

//   Multi-cycle RV32I control unit: next generation of the single-cycle controller.

---
 rtl/multicycle_controller_if.sv | 20 ++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory-side handshake bundle for the multi-cycle controller: instruction fetch
// port (req/ack plus IR latch strobe) and data port (req/ack plus store select).
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ack;
    logic ir_we;
    logic dmem_req;
    logic dmem_ack;
    logic mem_rw;

    modport master (
        output imem_req, ir_we, dmem_req, mem_rw,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, mem_rw,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: walks each instruction through FETCH/DECODE/EXEC/
// MEM/WB, handshakes with variable-latency memories, traps and counts retirements.
module multicycle_controller #(
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32,
    parameter logic [3:0] ALU_ADD     = 4'b0000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [31:0]             i_instr,
    input  logic [3:0]              i_alu_op,
    input  logic                    i_br_taken,
    multicycle_controller_if.master mem,
    output logic                    o_pc_we,
    output logic                    o_PCsel,
    output logic                    o_RegWen,
    output logic                    o_Asel,
    output logic                    o_Bsel,
    output logic [3:0]              o_ALU_sel,
    output logic [1:0]              o_wb_select,
    output logic                    o_trap,
    output logic [1:0]              o_trap_cause,
    output logic [CNT_W-1:0]        o_retired
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_AUIPC, C_LUI, C_ILL
    } cls_t;

    state_t         state_q, state_d;
    cls_t           cls;
    logic [TW-1:0]  tmo_q;
    logic           tmo_last;
    logic [1:0]     cause_q, cause_d;
    logic           sel_en;
    logic           sel_a, sel_b;
    logic [1:0]     sel_wb;
    logic [3:0]     sel_alu;
    logic           unused_instr_bits;

    assign unused_instr_bits = ^i_instr[31:7];

    always_comb begin
        case (i_instr[6:0])
            7'b0110011: cls = C_R;
            7'b0010011: cls = C_I;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = C_BR;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b0010111: cls = C_AUIPC;
            7'b0110111: cls = C_LUI;
            default:    cls = C_ILL;
        endcase
    end

    // Datapath select table; address/PC arithmetic always uses the adder.
    always_comb begin
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        sel_wb  = 2'b00;
        sel_alu = ALU_ADD;
        case (cls)
            C_R:     begin sel_wb = 2'b01; sel_alu = i_alu_op; end
            C_I:     begin sel_b = 1'b1; sel_wb = 2'b01; sel_alu = i_alu_op; end
            C_LOAD:  sel_b = 1'b1;
            C_STORE: sel_b = 1'b1;
            C_BR:    begin sel_a = 1'b1; sel_b = 1'b1; end
            C_JAL:   begin sel_a = 1'b1; sel_b = 1'b1; sel_wb = 2'b10; end
            C_JALR:  begin sel_b = 1'b1; sel_wb = 2'b10; end
            C_AUIPC: begin sel_a = 1'b1; sel_b = 1'b1; sel_wb = 2'b01; end
            C_LUI:   begin sel_a = 1'b1; sel_b = 1'b1; sel_wb = 2'b11; end
            default: ;
        endcase
    end

    assign tmo_last = (tmo_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        sel_en       = 1'b0;
        mem.imem_req = 1'b0;
        mem.ir_we    = 1'b0;
        mem.dmem_req = 1'b0;
        mem.mem_rw   = 1'b0;
        o_pc_we      = 1'b0;
        o_PCsel      = 1'b0;
        o_RegWen     = 1'b0;
        o_trap       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    mem.ir_we = 1'b1;
                    state_d   = S_DECODE;
                end else if (tmo_last) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_DECODE: begin
                sel_en = 1'b1;
                if (cls == C_ILL) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                sel_en = 1'b1;
                case (cls)
                    C_BR: begin
                        o_pc_we = 1'b1;
                        o_PCsel = i_br_taken;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                sel_en       = 1'b1;
                mem.dmem_req = 1'b1;
                mem.mem_rw   = (cls == C_STORE);
                if (mem.dmem_ack) begin
                    if (cls == C_STORE) begin
                        o_pc_we = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_last) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_WB: begin
                sel_en   = 1'b1;
                o_RegWen = 1'b1;
                o_pc_we  = 1'b1;
                o_PCsel  = (cls == C_JAL) || (cls == C_JALR);
                state_d  = S_FETCH;
            end
            S_TRAP: o_trap = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_Asel       = sel_en & sel_a;
    assign o_Bsel       = sel_en & sel_b;
    assign o_wb_select  = sel_en ? sel_wb : 2'b00;
    assign o_ALU_sel    = sel_en ? sel_alu : 4'b0000;
    assign o_trap_cause = cause_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Any state change restarts the wait count, so each FETCH/MEM visit starts at 0.
    always_ff @(posedge i_clk) begin
        if (i_reset || (state_d != state_q))
            tmo_q <= '0;
        else if ((mem.imem_req && !mem.imem_ack) || (mem.dmem_req && !mem.dmem_ack))
            tmo_q <= tmo_q + TW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_retired <= '0;
        else if (o_pc_we)
            o_retired <= o_retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus randomized instructions scored
// against a per-instruction transaction model (latency, strobes, selects).
module tb_multicycle_controller;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_instr;
    logic [3:0]  i_alu_op;
    logic        i_br_taken;
    logic        o_pc_we, o_PCsel, o_RegWen, o_Asel, o_Bsel, o_trap;
    logic [3:0]  o_ALU_sel;
    logic [1:0]  o_wb_select, o_trap_cause;
    logic [31:0] o_retired;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_alu_op(i_alu_op),
        .i_br_taken(i_br_taken), .mem(bus), .o_pc_we(o_pc_we), .o_PCsel(o_PCsel),
        .o_RegWen(o_RegWen), .o_Asel(o_Asel), .o_Bsel(o_Bsel), .o_ALU_sel(o_ALU_sel),
        .o_wb_select(o_wb_select), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_retired(o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;

    typedef struct {
        logic       a, b;
        logic [1:0] wb;
        logic [3:0] alu;
        int         base;
        int         nreg;
        logic       pcsel;
        bit         mem;
        bit         store;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.imem_req, bus.ir_we, bus.dmem_req, bus.mem_rw, o_pc_we, o_PCsel,
                  o_RegWen, o_Asel, o_Bsel, o_ALU_sel, o_wb_select, o_trap, o_trap_cause,
                  o_retired}, 64'd0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Instruction-level expectations from the opcode class table.
    function automatic exp_t model(input logic [31:0] ins, input logic [3:0] aop, input logic br);
        exp_t e;
        e.a = 0; e.b = 1; e.wb = 2'b00; e.alu = 4'b0000; e.base = 4; e.nreg = 1;
        e.pcsel = 0; e.mem = 0; e.store = 0;
        case (ins[6:0])
            7'b0110011: begin e.b = 0; e.wb = 2'b01; e.alu = aop; end
            7'b0010011: begin e.wb = 2'b01; e.alu = aop; end
            7'b0000011: begin e.base = 5; e.mem = 1; end
            7'b0100011: begin e.nreg = 0; e.mem = 1; e.store = 1; end
            7'b1100011: begin e.a = 1; e.base = 3; e.nreg = 0; e.pcsel = br; end
            7'b1101111: begin e.a = 1; e.wb = 2'b10; e.pcsel = 1; end
            7'b1100111: begin e.wb = 2'b10; e.pcsel = 1; end
            7'b0010111: begin e.a = 1; e.wb = 2'b01; end
            default:    begin e.a = 1; e.wb = 2'b11; end
        endcase
        return e;
    endfunction

    // Entered with the DUT in FETCH at posedge+1; leaves it in the next FETCH.
    task automatic run_instr(input string nm, input logic [31:0] ins, input logic [3:0] aop,
                             input logic br, input int iw, input int dw);
        exp_t e;
        int cyc = 0, ireq = 0, dreq = 0, npc = 0, nreg = 0, nir = 0, after_ir = -1;
        logic pcsel = 0, memrw_ok = 1, sel_ok = 1, done = 0;
        logic sa = 0, sb = 0;
        logic [1:0] swb = 0;
        logic [3:0] salu = 0;
        e = model(ins, aop, br);
        i_instr = ins; i_alu_op = aop; i_br_taken = br;
        while (!done && cyc < 80) begin
            bus.imem_ack = bus.imem_req && (ireq == iw);
            bus.dmem_ack = bus.dmem_req && (dreq == dw);
            #1;
            cyc++;
            if (bus.imem_req) ireq++;
            if (bus.dmem_req) begin
                dreq++;
                if (bus.mem_rw !== e.store) memrw_ok = 0;
            end
            if (after_ir >= 0) after_ir++;
            if (after_ir == 1) begin
                sa = o_Asel; sb = o_Bsel; swb = o_wb_select; salu = o_ALU_sel;
            end else if (after_ir > 1) begin
                if ({o_Asel, o_Bsel, o_wb_select, o_ALU_sel} !== {sa, sb, swb, salu}) sel_ok = 0;
            end
            if (bus.ir_we) begin nir++; after_ir = 0; end
            if (o_RegWen) nreg++;
            if (o_pc_we) begin npc++; pcsel = o_PCsel; done = 1; end
            tick();
        end
        bus.imem_ack = 0;
        bus.dmem_ack = 0;
        exp_ret++;
        chk({nm, "_latency"}, cyc, e.base + iw + (e.mem ? dw : 0));
        chk({nm, "_ir_we"}, nir, 1);
        chk({nm, "_pc_we"}, npc, 1);
        chk({nm, "_pcsel"}, pcsel, e.pcsel);
        chk({nm, "_regwen"}, nreg, e.nreg);
        chk({nm, "_dmem_cycles"}, dreq, e.mem ? dw + 1 : 0);
        chk({nm, "_memrw"}, memrw_ok, 1);
        chk({nm, "_asel"}, sa, e.a);
        chk({nm, "_bsel"}, sb, e.b);
        chk({nm, "_wbsel"}, swb, e.wb);
        chk({nm, "_alusel"}, salu, e.alu);
        chk({nm, "_sel_held"}, sel_ok, 1);
        chk({nm, "_no_trap"}, o_trap, 0);
        chk({nm, "_retired"}, o_retired, exp_ret);
        chk({nm, "_next_fetch"}, bus.imem_req, 1);
    endtask

    task automatic reset_to_fetch();
        bus.imem_ack = 0; bus.dmem_ack = 0;
        i_reset = 1;
        tick();
        i_reset = 0;
        exp_ret = 0;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [9];
        logic ok;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};
        i_reset = 1; i_instr = 0; i_alu_op = 0; i_br_taken = 0;
        bus.imem_ack = 0; bus.dmem_ack = 0;

        // Reset and release
        repeat (3) tick();
        chk_zero("reset_outputs");
        i_reset = 0;
        #1;
        chk("idle_no_req", bus.imem_req, 0);
        tick();
        chk("fetch_req_rises", bus.imem_req, 1);

        // Directed instructions
        run_instr("add", 32'h002081B3, 4'h5, 0, 0, 0);
        run_instr("lw", 32'h0040A283, 4'h3, 0, 0, 3);
        run_instr("beq_t", 32'h00208463, 4'h1, 1, 0, 0);
        run_instr("beq_nt", 32'h00208463, 4'h1, 0, 0, 0);
        run_instr("jal", 32'h008000EF, 4'h7, 0, 1, 0);
        run_instr("ack16_fetch", 32'h00500093, 4'h9, 0, 15, 0);
        run_instr("ack16_store", 32'h0020A223, 4'h2, 0, 0, 15);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            ins = {$urandom_range(0, 32'h1FFFFFF), 7'b0} | 32'(ops[$urandom_range(0, 8)]);
            run_instr("rand", ins, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 6), $urandom_range(0, 6));
        end

        // Instruction fetch timeout
        bus.imem_ack = 0;
        ok = 1;
        for (int k = 0; k < 16; k++) begin
            if (bus.imem_req !== 1'b1 || o_trap !== 1'b0) ok = 0;
            tick();
        end
        chk("imem_tmo_wait", ok, 1);
        chk("imem_tmo_trap", o_trap, 1);
        chk("imem_tmo_cause", o_trap_cause, 2'b01);
        chk("imem_tmo_req_drop", bus.imem_req, 0);
        bus.imem_ack = 1; bus.dmem_ack = 1;
        repeat (5) tick();
        chk("trap_sticky", {o_trap, o_trap_cause, o_pc_we, bus.ir_we}, {1'b1, 2'b01, 1'b0, 1'b0});
        bus.imem_ack = 0; bus.dmem_ack = 0;
        i_reset = 1;
        tick();
        chk_zero("reset_clears_trap");
        i_reset = 0;
        exp_ret = 0;
        tick();

        // Illegal opcode
        i_instr = 32'h0000007F;
        bus.imem_ack = 1;
        #1;
        chk("ill_ir_we", bus.ir_we, 1);
        tick();
        bus.imem_ack = 0;
        chk("ill_decode_no_trap", o_trap, 0);
        tick();
        chk("ill_trap", {o_trap, o_trap_cause, o_pc_we}, {1'b1, 2'b10, 1'b0});
        chk("ill_no_retire", o_retired, 0);

        // Data memory timeout on a store
        reset_to_fetch();
        i_instr = 32'h0020A223;
        bus.imem_ack = 1;
        tick();
        bus.imem_ack = 0;
        tick();
        tick();
        chk("sw_mem_req", {bus.dmem_req, bus.mem_rw}, 2'b11);
        ok = 1;
        for (int k = 0; k < 16; k++) begin
            if (bus.dmem_req !== 1'b1 || o_trap !== 1'b0) ok = 0;
            tick();
        end
        chk("dmem_tmo_wait", ok, 1);
        chk("dmem_tmo_trap", {o_trap, o_trap_cause, bus.dmem_req}, {1'b1, 2'b01, 1'b0});

        // Reset while waiting in MEM
        reset_to_fetch();
        i_instr = 32'h0040A283;
        bus.imem_ack = 1;
        tick();
        bus.imem_ack = 0;
        repeat (4) tick();
        chk("lw_mem_wait", {bus.dmem_req, bus.mem_rw}, 2'b10);
        i_reset = 1;
        tick();
        chk_zero("reset_in_mem");
        i_reset = 0;
        tick();
        chk("refetch_after_reset", bus.imem_req, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
